pll_sweep_ctrl: RTL

//  Frequency-select and PLL reconfiguration sequencer for the SDRAM memory tester.
//  - Turns debounced up/down/auto requests into a step index (pos) for the reconfig ROM mux.
//  - Drives the pll_reconfig handshake: write_from_rom, then reconfig, then wait for not-busy,

---
 rtl/pll_sweep_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pll_sweep_ctrl.sv
// PLL frequency-step selector and pll_reconfig handshake sequencer.
// Optional: PLL_SWEEP_TIMEOUT_CNT_EN adds a saturating timeout_cnt output.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   btn_up/down/auto    debounced button levels (rising edge = request)
//   passcount/failcount tester counters (foreign clock, monotonic)
//   pll_busy            pll_reconfig busy
//   pll_write_from_rom  1-cycle ROM load strobe
//   pll_reconfig        1-cycle apply strobe
//   pll_reconfig_reset  1-cycle strobe on reconfig timeout
//   pos                 frequency step index (0 = fastest)
//   auto_mode           auto sweep active
//   recfg               high for the whole reconfiguration sequence
//   timeout_cnt         (macro only) number of timeouts, saturating
module pll_sweep_ctrl #(
  parameter int NUM_STEPS   = 11,
  parameter int START_POS   = 7,
  parameter int TIMEOUT_CYC = 1000,
  parameter int SETTLE_CYC  = 2097152
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_auto,
  input  logic [31:0] passcount,
  input  logic [31:0] failcount,
  input  logic        pll_busy,
  output logic        pll_write_from_rom,
  output logic        pll_reconfig,
  output logic        pll_reconfig_reset,
  output logic [3:0]  pos,
  output logic        auto_mode,
`ifdef PLL_SWEEP_TIMEOUT_CNT_EN
  output logic [7:0]  timeout_cnt,
`endif
  output logic        recfg
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [3:0]    POS_MAX = 4'(NUM_STEPS - 1);
  localparam logic [3:0]    POS_RST = 4'(START_POS);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC);
  localparam logic [SW-1:0] ST_LOAD = SW'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_ARM,
    S_RECONF
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    btn_cur, btn_prev;
  logic [3:0]    pos_nxt;
  logic          auto_nxt, recfg_nxt;
  logic          wr_nxt, rc_nxt, start;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    guard, guard_nxt;
  logic [SW-1:0] settle, settle_nxt;
  logic          fail_s1, fail_s2;
  logic          up_ev, down_ev, auto_ev;

  assign up_ev   = btn_cur[0] & ~btn_prev[0];
  assign down_ev = btn_cur[1] & ~btn_prev[1];
  assign auto_ev = btn_cur[2] & ~btn_prev[2];

  // Both counters only ever grow, so the AND is a clean
  // monotonic level that is safe to synchronise bit-wise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_s1 <= 1'b0;
      fail_s2 <= 1'b0;
    end else begin
      fail_s1 <= (|failcount) & (|passcount);
      fail_s2 <= fail_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      btn_cur            <= '0;
      btn_prev           <= '0;
      pos                <= POS_RST;
      auto_mode          <= 1'b0;
      recfg              <= 1'b0;
      pll_write_from_rom <= 1'b0;
      pll_reconfig       <= 1'b0;
      timer              <= '0;
      guard              <= '0;
      settle             <= '0;
    end else begin
      state              <= state_nxt;
      btn_cur            <= {btn_auto, btn_down, btn_up};
      btn_prev           <= btn_cur;
      pos                <= pos_nxt;
      auto_mode          <= auto_nxt;
      recfg              <= recfg_nxt;
      pll_write_from_rom <= wr_nxt;
      pll_reconfig       <= rc_nxt;
      timer              <= timer_nxt;
      guard              <= guard_nxt;
      settle             <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    pos_nxt            = pos;
    auto_nxt           = auto_mode;
    recfg_nxt          = recfg;
    wr_nxt             = 1'b0;
    rc_nxt             = 1'b0;
    start              = 1'b0;
    timer_nxt          = timer;
    guard_nxt          = guard;
    settle_nxt         = settle;
    pll_reconfig_reset = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (settle != '0)
          settle_nxt = settle - SW'(1);
        if (auto_ev) begin
          start    = 1'b1;
          auto_nxt = ~auto_mode;
          if (!auto_mode)
            pos_nxt = 4'd0;
        end else if (down_ev && pos < POS_MAX) begin
          start    = 1'b1;
          auto_nxt = 1'b0;
          pos_nxt  = pos + 4'd1;
        end else if (up_ev && pos != 4'd0) begin
          start    = 1'b1;
          auto_nxt = 1'b0;
          pos_nxt  = pos - 4'd1;
        end else if (auto_mode && settle == '0 &&
                     fail_s2 && pos < POS_MAX) begin
          start   = 1'b1;
          pos_nxt = pos + 4'd1;
        end
        if (start) begin
          recfg_nxt = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        wr_nxt    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_ARM;
      S_ARM: begin
        if (!pll_busy) begin
          rc_nxt    = 1'b1;
          timer_nxt = TO_LOAD;
          guard_nxt = 2'd2;
          state_nxt = S_RECONF;
        end
      end
      S_RECONF: begin
        timer_nxt = timer - TW'(1);
        if (guard != 2'd0)
          guard_nxt = guard - 2'd1;
        // Timeout is checked first so it wins a tie.
        if (timer == TW'(1)) begin
          pll_reconfig_reset = 1'b1;
          recfg_nxt          = 1'b0;
          settle_nxt         = ST_LOAD;
          state_nxt          = S_IDLE;
        end else if (guard == 2'd0 && !pll_busy) begin
          recfg_nxt  = 1'b0;
          settle_nxt = ST_LOAD;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef PLL_SWEEP_TIMEOUT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timeout_cnt <= '0;
    else if (pll_reconfig_reset && timeout_cnt != 8'hFF)
      timeout_cnt <= timeout_cnt + 8'd1;
  end
`endif

endmodule
